// File: rtl/pulse_sequencer.sv
// pulse_sequencer: walks a contiguous run of pulse-memory entries, holds each
// pulse until its start time on a local timeline, hands it to the generator
// over valid/ready, then waits out its duration before fetching the next one.
// The start-time compare uses the timer value of the following cycle, so a
// pulse presented on time shows pulse_valid in the cycle where timer == t_start.
module pulse_sequencer #(
   parameter int ADDR_W   = 5,
   parameter int TSTART_W = 32,
   parameter int TLEN_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     num_pulses,
   input  logic                abort,
   output logic [31:0]         fetch_addr,
   input  logic [TSTART_W-1:0] fetch_t_start,
   input  logic [TLEN_W-1:0]   fetch_t_len,
   output logic                pulse_valid,
   input  logic                pulse_ready,
   output logic [ADDR_W-1:0]   pulse_idx,
   output logic [TSTART_W-1:0] timer,
   output logic                busy,
   output logic                done,
   output logic                late_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_PLAY,
      S_NEXT
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [TLEN_W-1:0]   play_q, play_d;
   logic [ADDR_W-1:0]   idx_d;
   logic [TSTART_W-1:0] timer_d;
   logic [TSTART_W-1:0] timer_inc;
   logic                late_d;
   logic                busy_d;
   logic                done_d;
   logic                valid_d;

   // Saturating increment: the value timer shows in the next cycle.
   assign timer_inc = (&timer) ? timer : timer + TSTART_W'(1);

   // Next-state and next-value logic for the sequencer and its counters.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      play_d  = play_q;
      idx_d   = pulse_idx;
      timer_d = timer;
      late_d  = late_err;

      case (state_q)
         S_IDLE: begin
            // A start coinciding with abort is dropped.
            if (start && !abort) begin
               idx_d   = base_addr;
               rem_d   = num_pulses;
               timer_d = '0;
               late_d  = 1'b0;
               state_d = (num_pulses == '0) ? S_NEXT : S_FETCH;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            // Compare against next cycle's timer so ISSUE lands on t_start.
            if (timer_inc >= fetch_t_start) begin
               state_d = S_ISSUE;
               if (timer_inc > fetch_t_start) late_d = 1'b1;
            end
         end
         S_ISSUE: begin
            if (pulse_ready) begin
               play_d  = fetch_t_len;
               state_d = (fetch_t_len == '0) ? S_NEXT : S_PLAY;
            end
         end
         S_PLAY: begin
            play_d = play_q - TLEN_W'(1);
            if (play_q == TLEN_W'(1)) state_d = S_NEXT;
         end
         S_NEXT: begin
            rem_d = rem_q - (ADDR_W+1)'(1);
            // rem_q of 0 only happens for an empty sequence: finish as well.
            if (rem_q <= (ADDR_W+1)'(1)) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = pulse_idx + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE) timer_d = timer_inc;

      // Abort overrides every other transition; late_err and timer hold.
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_ISSUE);
      done_d  = (state_d == S_NEXT) && (rem_d <= (ADDR_W+1)'(1));
   end

   // Sequencer state and internal counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         play_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         play_q  <= play_d;
      end
   end

   // Registered outputs, loaded from their next values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_addr  <= '0;
         pulse_idx   <= '0;
         timer       <= '0;
         pulse_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         late_err    <= 1'b0;
      end else begin
         fetch_addr  <= 32'(idx_d);
         pulse_idx   <= idx_d;
         timer       <= timer_d;
         pulse_valid <= valid_d;
         busy        <= busy_d;
         done        <= done_d;
         late_err    <= late_d;
      end
   end

endmodule
